// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access with round-robin
// tie-breaking, a registered req/done handshake and a per-access ack timeout.
module mem_port_arbiter #(
   parameter int unsigned BUSW    = 32,
   parameter int unsigned MINDW   = 12,
   parameter int unsigned TIMEOUT = 15,
   parameter int unsigned TOW     = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             if_req,
   input  logic [MINDW-1:0] if_addr,
   output logic             if_done,
   output logic             if_err,
   output logic [BUSW-1:0]  if_rdata,
   input  logic             d_req,
   input  logic             d_we,
   input  logic [MINDW-1:0] d_addr,
   input  logic [BUSW-1:0]  d_wdata,
   output logic             d_done,
   output logic             d_err,
   output logic [BUSW-1:0]  d_rdata,
   output logic             mem_req,
   output logic             mem_we,
   output logic [MINDW-1:0] mem_addr,
   output logic [BUSW-1:0]  mem_wdata,
   input  logic [BUSW-1:0]  mem_rdata,
   input  logic             mem_ack,
   output logic             busy
);

   typedef enum logic [1:0] {StIdle, StGrantIf, StGrantD, StComplete} state_e;

   state_e           state_q, state_d;
   logic [TOW-1:0]   cnt_q, cnt_d;
   logic             last_d_q, last_d_d;   // 1: last grant went to the data port
   logic             err_q, err_d;         // timeout result carried into COMPLETE
   logic             if_done_q, if_done_d, if_err_q, if_err_d;
   logic             d_done_q, d_done_d, d_err_q, d_err_d;
   logic [BUSW-1:0]  if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
   logic             mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [MINDW-1:0] mem_addr_q, mem_addr_d;
   logic [BUSW-1:0]  mem_wdata_q, mem_wdata_d;
   logic             busy_q, busy_d;
   logic             gnt_d;
   logic [BUSW-1:0]  rdata_nxt;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      last_d_d    = last_d_q;
      err_d       = err_q;
      if_done_d   = 1'b0;
      if_err_d    = 1'b0;
      d_done_d    = 1'b0;
      d_err_d     = 1'b0;
      if_rdata_d  = if_rdata_q;
      d_rdata_d   = d_rdata_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      gnt_d       = 1'b0;
      rdata_nxt   = '0;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (if_req || d_req) begin
               // On a tie the port that was not served last wins.
               gnt_d       = d_req && (!if_req || !last_d_q);
               last_d_d    = gnt_d;
               mem_req_d   = 1'b1;
               mem_we_d    = gnt_d && d_we;
               mem_addr_d  = gnt_d ? d_addr : if_addr;
               mem_wdata_d = gnt_d ? d_wdata : '0;
               state_d     = gnt_d ? StGrantD : StGrantIf;
            end
         end
         StGrantIf, StGrantD: begin
            cnt_d = cnt_q + TOW'(1);
            if (mem_ack || (cnt_q == TOW'(TIMEOUT - 1))) begin
               rdata_nxt = (mem_ack && !mem_we_q) ? mem_rdata : '0;
               err_d     = !mem_ack;
               mem_req_d = 1'b0;
               state_d   = StComplete;
               if (state_q == StGrantD) d_rdata_d = rdata_nxt;
               else                     if_rdata_d = rdata_nxt;
            end
         end
         StComplete: begin
            cnt_d   = '0;
            state_d = StIdle;
            if (last_d_q) begin
               d_done_d = 1'b1;
               d_err_d  = err_q;
            end else begin
               if_done_d = 1'b1;
               if_err_d  = err_q;
            end
         end
         default: state_d = StIdle;
      endcase
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         last_d_q    <= 1'b1;
         err_q       <= 1'b0;
         if_done_q   <= 1'b0;
         if_err_q    <= 1'b0;
         d_done_q    <= 1'b0;
         d_err_q     <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_d_q    <= last_d_d;
         err_q       <= err_d;
         if_done_q   <= if_done_d;
         if_err_q    <= if_err_d;
         d_done_q    <= d_done_d;
         d_err_q     <= d_err_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= busy_d;
      end
   end

   assign if_done   = if_done_q;
   assign if_err    = if_err_q;
   assign if_rdata  = if_rdata_q;
   assign d_done    = d_done_q;
   assign d_err     = d_err_q;
   assign d_rdata   = d_rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: handshake latency, round-robin, timeout, async reset.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0;
   logic [11:0] if_addr = '0;
   logic        if_done, if_err;
   logic [31:0] if_rdata;
   logic        d_req = 1'b0, d_we = 1'b0;
   logic [11:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic        d_done, d_err;
   logic [31:0] d_rdata;
   logic        mem_req, mem_we;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;
   int n;

   mem_port_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_done   (if_done),
      .if_err    (if_err),
      .if_rdata  (if_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_done    (d_done),
      .d_err     (d_err),
      .d_rdata   (d_rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // Reset state
      tick();
      check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);
      check_eq("rst_done", {30'd0, if_done, d_done}, 32'd0);
      check_eq("rst_rdata", if_rdata | d_rdata, 32'd0);
      tick();
      rst_n = 1'b1;

      // 1: single fetch, ack one cycle after mem_req
      if_req = 1'b1; if_addr = 12'h002;
      tick();
      check_eq("t1_mem_req", {31'd0, mem_req}, 32'd1);
      check_eq("t1_mem_addr", {20'd0, mem_addr}, 32'h002);
      check_eq("t1_mem_we0", {31'd0, mem_we}, 32'd0);
      check_eq("t1_busy", {31'd0, busy}, 32'd1);
      mem_ack = 1'b1; mem_rdata = 32'h1000_0000;
      tick();
      mem_ack = 1'b0;
      check_eq("t1_mem_req_drop", {31'd0, mem_req}, 32'd0);
      check_eq("t1_done_early", {31'd0, if_done}, 32'd0);
      check_eq("t1_mem_we1", {31'd0, mem_we}, 32'd0);
      tick();
      check_eq("t1_if_done", {31'd0, if_done}, 32'd1);
      check_eq("t1_if_rdata", if_rdata, 32'h1000_0000);
      check_eq("t1_if_err", {31'd0, if_err}, 32'd0);
      check_eq("t1_busy_done", {31'd0, busy}, 32'd0);
      if_req = 1'b0;
      tick();
      check_eq("t1_done_pulse", {31'd0, if_done}, 32'd0);
      check_eq("t1_no_regrant", {31'd0, mem_req}, 32'd0);

      // 2: tie after reset goes to fetch, then store, then round-robin back to fetch
      do_reset();
      if_req = 1'b1; if_addr = 12'h003;
      d_req = 1'b1; d_we = 1'b1; d_addr = 12'h001; d_wdata = 32'h71;
      tick();
      check_eq("t2_first_if_we", {31'd0, mem_we}, 32'd0);
      check_eq("t2_first_if_addr", {20'd0, mem_addr}, 32'h003);
      mem_ack = 1'b1; mem_rdata = 32'h0000_AAAA;
      tick();
      mem_ack = 1'b0;
      tick();
      check_eq("t2_if_done", {31'd0, if_done}, 32'd1);
      check_eq("t2_if_rdata", if_rdata, 32'h0000_AAAA);
      check_eq("t2_d_done_not", {31'd0, d_done}, 32'd0);
      if_req = 1'b0;
      tick();
      check_eq("t2_st_req", {31'd0, mem_req}, 32'd1);
      check_eq("t2_st_we", {31'd0, mem_we}, 32'd1);
      check_eq("t2_st_addr", {20'd0, mem_addr}, 32'h001);
      check_eq("t2_st_wdata", mem_wdata, 32'h71);
      mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      tick();
      mem_ack = 1'b0;
      tick();
      check_eq("t2_d_done", {31'd0, d_done}, 32'd1);
      check_eq("t2_st_rdata", d_rdata, 32'd0);
      check_eq("t2_d_err", {31'd0, d_err}, 32'd0);
      // d_req stays high as a new load; fetch rises too: tie must go to fetch
      if_req = 1'b1; if_addr = 12'h005; d_we = 1'b0;
      tick();
      check_eq("t2_rr_we", {31'd0, mem_we}, 32'd0);
      check_eq("t2_rr_addr", {20'd0, mem_addr}, 32'h005);
      mem_ack = 1'b1; mem_rdata = 32'h0000_0BBB;
      tick();
      mem_ack = 1'b0;
      tick();
      check_eq("t2_rr_if_done", {31'd0, if_done}, 32'd1);
      if_req = 1'b0;
      tick();
      check_eq("t2_ld_addr", {20'd0, mem_addr}, 32'h001);
      check_eq("t2_ld_we", {31'd0, mem_we}, 32'd0);
      mem_ack = 1'b1; mem_rdata = 32'h0000_1234;
      tick();
      mem_ack = 1'b0;
      tick();
      check_eq("t2_ld_done", {31'd0, d_done}, 32'd1);
      check_eq("t2_ld_rdata", d_rdata, 32'h0000_1234);
      d_req = 1'b0;
      tick();

      // 3: no ack -> timeout after 15 cycles with mem_req high
      d_req = 1'b1; d_we = 1'b0; d_addr = 12'h0FF;
      tick();
      n = 0;
      while (mem_req && n < 40) begin
         n++;
         tick();
      end
      check_eq("t3_req_cycles", n, 32'd15);
      check_eq("t3_done_early", {31'd0, d_done}, 32'd0);
      tick();
      check_eq("t3_d_done", {31'd0, d_done}, 32'd1);
      check_eq("t3_d_err", {31'd0, d_err}, 32'd1);
      check_eq("t3_d_rdata", d_rdata, 32'd0);
      d_req = 1'b0;
      tick();
      check_eq("t3_err_clear", {31'd0, d_err}, 32'd0);
      d_req = 1'b1; d_addr = 12'h010;
      tick();
      check_eq("t3_next_req", {31'd0, mem_req}, 32'd1);
      mem_ack = 1'b1; mem_rdata = 32'h0000_0055;
      tick();
      mem_ack = 1'b0;
      tick();
      check_eq("t3_next_done", {31'd0, d_done}, 32'd1);
      check_eq("t3_next_err", {31'd0, d_err}, 32'd0);
      check_eq("t3_next_rdata", d_rdata, 32'h0000_0055);
      d_req = 1'b0;
      tick();

      // 4: ack in the 15th GRANT cycle wins over the timeout
      d_req = 1'b1; d_addr = 12'h0FE;
      tick();
      for (int i = 0; i < 14; i++) tick();
      check_eq("t4_req_still", {31'd0, mem_req}, 32'd1);
      mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
      tick();
      mem_ack = 1'b0;
      tick();
      check_eq("t4_d_done", {31'd0, d_done}, 32'd1);
      check_eq("t4_d_err", {31'd0, d_err}, 32'd0);
      check_eq("t4_d_rdata", d_rdata, 32'hCAFE_F00D);
      d_req = 1'b0;
      tick();

      // 5: async reset during GRANT_D, then re-grant of the held request
      d_req = 1'b1; d_we = 1'b1; d_addr = 12'h005; d_wdata = 32'h9;
      tick();
      check_eq("t5_granted", {31'd0, mem_req}, 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("t5_async_req", {31'd0, mem_req}, 32'd0);
      check_eq("t5_async_busy", {31'd0, busy}, 32'd0);
      check_eq("t5_async_addr", {19'd0, mem_we, mem_addr}, 32'd0);
      check_eq("t5_async_rdata", d_rdata, 32'd0);
      n = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n += int'(d_done);
      end
      rst_n = 1'b1;
      tick();
      n += int'(d_done);
      check_eq("t5_no_done", n, 32'd0);
      check_eq("t5_regrant_we", {31'd0, mem_we}, 32'd1);
      check_eq("t5_regrant_addr", {20'd0, mem_addr}, 32'h005);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      tick();
      check_eq("t5_d_done", {31'd0, d_done}, 32'd1);
      d_req = 1'b0;
      tick();

      // 6: stray ack in IDLE ignored; held d_req starts a second access
      mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
      tick();
      mem_ack = 1'b0;
      check_eq("t6_stray_busy", {31'd0, busy}, 32'd0);
      check_eq("t6_stray_req", {31'd0, mem_req}, 32'd0);
      tick();
      check_eq("t6_stray_done", {30'd0, if_done, d_done}, 32'd0);
      d_req = 1'b1; d_we = 1'b0; d_addr = 12'h007;
      tick();
      mem_ack = 1'b1; mem_rdata = 32'h0000_0111;
      tick();
      mem_ack = 1'b0;
      tick();
      check_eq("t6_first_done", {31'd0, d_done}, 32'd1);
      check_eq("t6_first_rdata", d_rdata, 32'h0000_0111);
      tick();
      check_eq("t6_second_req", {31'd0, mem_req}, 32'd1);
      check_eq("t6_second_addr", {20'd0, mem_addr}, 32'h007);
      mem_ack = 1'b1; mem_rdata = 32'h0000_0222;
      tick();
      mem_ack = 1'b0;
      tick();
      check_eq("t6_second_done", {31'd0, d_done}, 32'd1);
      check_eq("t6_second_rdata", d_rdata, 32'h0000_0222);
      d_req = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
